// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter: accepts one W-bit word via valid/ready and
// emits it one bit per consumed cycle, LSB- or MSB-first, with a done pulse.
module shift_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         SRL,
    input  logic         shift_en,
    output logic         Sout,
    output logic         Sout_valid,
    output logic         last,
    output logic         done
);

    localparam int CW = $clog2(W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state_q;
    logic [W-1:0]   shreg_q;
    logic [W-1:0]   shreg_d;
    logic [CW-1:0]  cnt_q;
    logic           dir_q;
    logic           done_q;
    logic           at_last;
    logic           accept;

    assign at_last = (cnt_q == CW'(W - 1));
    assign accept  = load_valid && load_ready;

    // Zero-filled shift toward whichever end is currently driving Sout.
    always_comb begin
        shreg_d = shreg_q;
        if (dir_q) begin
            shreg_d = {1'b0, shreg_q[W-1:1]};
        end else begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= in;
                        dir_q   <= SRL;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (at_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            shreg_q <= '0;
                            cnt_q   <= '0;
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // load_ready is gated by rst directly so it is low for the whole reset.
    assign load_ready = (state_q == IDLE) && !rst;
    assign Sout_valid = (state_q == SHIFT);
    assign last       = (state_q == SHIFT) && at_last;
    assign Sout       = (state_q == SHIFT) ? (dir_q ? shreg_q[0] : shreg_q[W-1]) : 1'b0;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: a frame-level reference model checked
// every cycle, plus literal bit sequences for the documented scenarios.
module tb_shift_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         SRL = 1'b0;
    logic         shift_en = 1'b0;
    logic         Sout;
    logic         Sout_valid;
    logic         last;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    shift_serializer #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .SRL        (SRL),
        .shift_en   (shift_en),
        .Sout       (Sout),
        .Sout_valid (Sout_valid),
        .last       (last),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Frame-level model: the word is unrolled into transmit order at accept,
    // then an index walks it as bits are consumed.
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_idx  = 0;
    logic m_frame [W];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_idx  = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (load_valid) begin
                    for (int i = 0; i < W; i++)
                        m_frame[i] = SRL ? in[i] : in[W-1-i];
                    m_idx  = 0;
                    m_busy = 1'b1;
                end
            end else if (shift_en) begin
                if (m_idx == W - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model.Sout",       Sout,       m_busy ? m_frame[m_idx] : 1'b0);
        check("model.Sout_valid", Sout_valid, m_busy);
        check("model.last",       last,       m_busy && (m_idx == W - 1));
        check("model.load_ready", load_ready, !rst && !m_busy);
        check("model.done",       done,       m_done);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Loads a word with shift_en held high and checks each bit against a literal list.
    task automatic send_check(input logic [W-1:0] word, input logic srl, input logic toggle_srl,
                              input logic [W-1:0] exp_bits);
        in = word;
        SRL = srl;
        load_valid = 1'b1;
        shift_en = 1'b1;
        next_cycle();
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (toggle_srl && i == 3) SRL = ~SRL;
            @(negedge clk);
            check("lit.bit",        Sout,       exp_bits[W-1-i]);
            check("lit.last",       last,       (i == W - 1));
            check("lit.load_ready", load_ready, 1'b0);
            check("lit.done_low",   done,       1'b0);
            next_cycle();
        end
        @(negedge clk);
        check("lit.done",       done,       1'b1);
        check("lit.ready_back", load_ready, 1'b1);
        check("lit.valid_off",  Sout_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("lit.done_once",  done,       1'b0);
        next_cycle();
    endtask

    // Per-cycle Sout for LSB-first 8'hB1 with shift_en low in cycles 3..5.
    logic [10:0] stall_bits = 11'b100_0000_1101;

    initial begin
        // Reset held: outputs quiet, load_ready forced low.
        next_cycle();
        @(negedge clk);
        check("rst.load_ready", load_ready, 1'b0);
        check("rst.Sout_valid", Sout_valid, 1'b0);
        check("rst.Sout",       Sout,       1'b0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.load_ready", load_ready, 1'b1);
        check("post_rst.done",       done,       1'b0);
        next_cycle();

        // LSB-first 8'hB1: 1,0,0,0,1,1,0,1
        send_check(8'hB1, 1'b1, 1'b0, 8'b1000_1101);
        // MSB-first 8'hB1 with SRL toggled mid-frame: 1,0,1,1,0,0,0,1
        send_check(8'hB1, 1'b0, 1'b1, 8'b1011_0001);

        // Stall for three cycles after the third bit.
        in = 8'hB1;
        SRL = 1'b1;
        load_valid = 1'b1;
        shift_en = 1'b1;
        next_cycle();
        load_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            shift_en = !(c >= 3 && c < 6);
            @(negedge clk);
            check("stall.bit",   Sout,       stall_bits[10-c]);
            check("stall.valid", Sout_valid, 1'b1);
            check("stall.done",  done,       1'b0);
            next_cycle();
        end
        shift_en = 1'b1;
        @(negedge clk);
        check("stall.done_late", done, 1'b1);
        next_cycle();

        // load_valid during a frame of 8'h00 is ignored.
        in = 8'h00;
        load_valid = 1'b1;
        next_cycle();
        load_valid = 1'b0;
        for (int c = 0; c < W; c++) begin
            if (c == 3) begin
                in = 8'hFF;
                load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            check("busy.bit", Sout, 1'b0);
            next_cycle();
        end
        load_valid = 1'b0;
        @(negedge clk);
        check("busy.done", done, 1'b1);
        next_cycle();
        @(negedge clk);
        check("busy.no_second", Sout_valid, 1'b0);
        next_cycle();

        // Back-to-back: 8'h01 then 8'h80 accepted in the done cycle.
        in = 8'h01;
        SRL = 1'b1;
        load_valid = 1'b1;
        next_cycle();
        in = 8'h80;
        for (int t = 0; t < 17; t++) begin
            if (t == 9) load_valid = 1'b0;
            @(negedge clk);
            if (t == 8) begin
                check("b2b.done",       done,       1'b1);
                check("b2b.gap_valid",  Sout_valid, 1'b0);
                check("b2b.gap_ready",  load_ready, 1'b1);
            end else begin
                check("b2b.valid", Sout_valid, 1'b1);
                check("b2b.bit",   Sout,       (t == 0 || t == 16));
                check("b2b.last",  last,       (t == 7 || t == 16));
            end
            next_cycle();
        end
        next_cycle();
        next_cycle();

        // Async reset between edges at the fourth bit.
        in = 8'hB1;
        SRL = 1'b1;
        load_valid = 1'b1;
        next_cycle();
        load_valid = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        #2;
        check("arst.pre_valid", Sout_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("arst.valid", Sout_valid, 1'b0);
        check("arst.last",  last,       1'b0);
        check("arst.done",  done,       1'b0);
        check("arst.ready", load_ready, 1'b0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("arst.ready_after", load_ready, 1'b1);
        check("arst.no_done",     done,       1'b0);
        next_cycle();
        send_check(8'hB1, 1'b1, 1'b0, 8'b1000_1101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
